// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, datapath widths
// and the controller FSM state encoding.
package alu_pkg;

   localparam int OPW  = 5;
   localparam int DW   = 32;
   localparam int RESW = 67;
   localparam int REMW = 33;
   localparam int CNTW = 16;

   localparam logic [OPW-1:0] OP_NOP = 5'd0;
   localparam logic [OPW-1:0] OP_ADD = 5'd1;
   localparam logic [OPW-1:0] OP_SUB = 5'd2;
   localparam logic [OPW-1:0] OP_MUL = 5'd3;
   localparam logic [OPW-1:0] OP_DIV = 5'd4;
   localparam logic [OPW-1:0] OP_SHL = 5'd5;
   localparam logic [OPW-1:0] OP_SHR = 5'd6;
   localparam logic [OPW-1:0] OP_AND = 5'd7;
   localparam logic [OPW-1:0] OP_OR  = 5'd8;
   localparam logic [OPW-1:0] OP_XOR = 5'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the command, ALU-drive and result ports of the issue controller.
interface alu_issue_ctrl_if;
   import alu_pkg::*;

   // Both ports use valid/ready: a transfer happens on a rising edge where
   // valid and ready are both high; valid, once raised, holds its payload
   // stable until that edge, and ready never depends combinationally on valid.
   logic            in_valid;
   logic            in_ready;
   logic [OPW-1:0]  in_op;
   logic [DW-1:0]   in_x;
   logic [DW-1:0]   in_y;

   logic [OPW-1:0]  alu_op;
   logic [DW-1:0]   alu_x;
   logic [DW-1:0]   alu_y;
   logic [RESW-1:0] alu_result;
   logic [REMW-1:0] alu_remainder;

   logic            out_valid;
   logic            out_ready;
   logic [RESW-1:0] out_result;
   logic [REMW-1:0] out_remainder;
   logic            out_err;

   modport master (
      input  in_valid, in_op, in_x, in_y, alu_result, alu_remainder, out_ready,
      output in_ready, alu_op, alu_x, alu_y, out_valid, out_result,
             out_remainder, out_err
   );

   modport slave (
      output in_valid, in_op, in_x, in_y, alu_result, alu_remainder, out_ready,
      input  in_ready, alu_op, alu_x, alu_y, out_valid, out_result,
             out_remainder, out_err
   );

endinterface

// File: rtl/alu_issue_ctrl_latency_lut.sv
// Opcode to RUN-cycle-count lookup; op_valid is low for opcodes outside 1..9.
module alu_latency_lut
   import alu_pkg::*;
#(
   parameter int ADDSUB_CYCLES = 2,
   parameter int MUL_CYCLES    = 34,
   parameter int DIV_CYCLES    = 34,
   parameter int LOGIC_CYCLES  = 2
) (
   input  logic [OPW-1:0]  op,
   output logic [CNTW-1:0] cycles,
   output logic            op_valid
);

   always_comb begin
      cycles   = '0;
      op_valid = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            cycles   = CNTW'(ADDSUB_CYCLES);
            op_valid = 1'b1;
         end
         OP_MUL: begin
            cycles   = CNTW'(MUL_CYCLES);
            op_valid = 1'b1;
         end
         OP_DIV: begin
            cycles   = CNTW'(DIV_CYCLES);
            op_valid = 1'b1;
         end
         OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR: begin
            cycles   = CNTW'(LOGIC_CYCLES);
            op_valid = 1'b1;
         end
         default: begin
            cycles   = '0;
            op_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the multi-cycle ALU: holds one command on the ALU for
// its fixed latency, captures the result, and inserts an op=0 gap afterwards.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int ADDSUB_CYCLES = 2,
   parameter int MUL_CYCLES    = 34,
   parameter int DIV_CYCLES    = 34,
   parameter int LOGIC_CYCLES  = 2
) (
   input  logic              clk,
   input  logic              rst,
   alu_issue_ctrl_if.master  bus,
   output state_t            dbg_state
);

   state_t          state;
   logic [OPW-1:0]  cmd_op;
   logic [CNTW-1:0] cnt;
   logic            in_ready_q;
   logic [OPW-1:0]  alu_op_q;
   logic [DW-1:0]   alu_x_q;
   logic [DW-1:0]   alu_y_q;
   logic            out_valid_q;
   logic [RESW-1:0] out_result_q;
   logic [REMW-1:0] out_remainder_q;
   logic            out_err_q;

   logic [CNTW-1:0] lut_cycles;
   logic            lut_valid;
   logic            cmd_bad;

   alu_latency_lut #(
      .ADDSUB_CYCLES (ADDSUB_CYCLES),
      .MUL_CYCLES    (MUL_CYCLES),
      .DIV_CYCLES    (DIV_CYCLES),
      .LOGIC_CYCLES  (LOGIC_CYCLES)
   ) u_lut (
      .op       (bus.in_op),
      .cycles   (lut_cycles),
      .op_valid (lut_valid)
   );

   assign cmd_bad = !lut_valid || ((bus.in_op == OP_DIV) && (bus.in_y == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         cmd_op          <= OP_NOP;
         cnt             <= '0;
         in_ready_q      <= 1'b1;
         alu_op_q        <= OP_NOP;
         alu_x_q         <= '0;
         alu_y_q         <= '0;
         out_valid_q     <= 1'b0;
         out_result_q    <= '0;
         out_remainder_q <= '0;
         out_err_q       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  cmd_op     <= bus.in_op;
                  in_ready_q <= 1'b0;
                  if (cmd_bad) begin
                     // Rejected commands never reach the ALU; report straight away.
                     state           <= ST_HOLD;
                     out_valid_q     <= 1'b1;
                     out_result_q    <= '0;
                     out_remainder_q <= '0;
                     out_err_q       <= 1'b1;
                  end else begin
                     state    <= ST_RUN;
                     alu_op_q <= bus.in_op;
                     alu_x_q  <= bus.in_x;
                     alu_y_q  <= bus.in_y;
                     cnt      <= lut_cycles;
                  end
               end
            end
            ST_RUN: begin
               if (cnt <= CNTW'(1)) begin
                  // Last driven cycle: the ALU output is final on this edge.
                  state           <= ST_HOLD;
                  cnt             <= '0;
                  alu_op_q        <= OP_NOP;
                  out_valid_q     <= 1'b1;
                  out_result_q    <= bus.alu_result;
                  out_remainder_q <= (cmd_op == OP_DIV) ? bus.alu_remainder : '0;
                  out_err_q       <= 1'b0;
               end else begin
                  cnt <= cnt - CNTW'(1);
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  state       <= ST_GAP;
                  out_valid_q <= 1'b0;
               end
            end
            ST_GAP: begin
               state      <= ST_IDLE;
               in_ready_q <= 1'b1;
            end
            default: begin
               state      <= ST_IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.alu_op        = alu_op_q;
   assign bus.alu_x         = alu_x_q;
   assign bus.alu_y         = alu_y_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_result    = out_result_q;
   assign bus.out_remainder = out_remainder_q;
   assign bus.out_err       = out_err_q;
   assign dbg_state         = state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a cycle-accurate ALU stand-in whose
// result only becomes correct after the operands have been held long enough.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t dbg_state;
   int     n_checks = 0;
   int     n_fail = 0;
   int     held = 0;

   alu_issue_ctrl_if bus();

   alu_issue_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // ALU stand-in: garbage until the op has been driven for its full latency
   function automatic int lat_of(input logic [4:0] op);
      case (op)
         5'd3, 5'd4: lat_of = 34;
         default:    lat_of = 2;
      endcase
   endfunction

   always @(posedge clk) held <= (bus.alu_op == 5'd0) ? 0 : held + 1;

   always_comb begin
      bus.alu_result    = 67'h5_DEAD_BEEF_0BAD_F00D;
      bus.alu_remainder = 33'h1_2345_6789;
      if (bus.alu_op != 5'd0 && held >= lat_of(bus.alu_op) - 1) begin
         case (bus.alu_op)
            5'd1: bus.alu_result = {35'b0, bus.alu_x + bus.alu_y};
            5'd2: bus.alu_result = {35'b0, bus.alu_x - bus.alu_y};
            5'd3: bus.alu_result = {3'b0, 64'(bus.alu_x) * 64'(bus.alu_y)};
            5'd4: begin
               if (bus.alu_y != 0) begin
                  bus.alu_result    = {35'b0, bus.alu_x / bus.alu_y};
                  bus.alu_remainder = {1'b0, bus.alu_x % bus.alu_y};
               end
            end
            5'd5: bus.alu_result = {35'b0, bus.alu_x << bus.alu_y[4:0]};
            5'd6: bus.alu_result = {35'b0, bus.alu_x >> bus.alu_y[4:0]};
            5'd7: bus.alu_result = {35'b0, bus.alu_x & bus.alu_y};
            5'd8: bus.alu_result = {35'b0, bus.alu_x | bus.alu_y};
            5'd9: bus.alu_result = {35'b0, bus.alu_x ^ bus.alu_y};
            default: ;
         endcase
      end
   end

   task automatic check_eq(input string tag, input logic [66:0] act, input logic [66:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // driver: waits for in_ready, presents one command across one accept edge
   task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      int guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check_eq("issue_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_x     = x;
      bus.in_y     = y;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // issue, then follow the ALU drive and wait (bounded) for out_valid
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] x,
                         input logic [31:0] y, input int exp_lat, input int exp_drive,
                         input logic [66:0] exp_res, input logic [32:0] exp_rem,
                         input logic exp_err);
      int lat = 0;
      int drive = 0;
      int bad = 0;
      issue(op, x, y);
      while (1) begin
         @(negedge clk);
         lat++;
         if (bus.alu_op != 5'd0) begin
            drive++;
            if (bus.alu_op !== op || bus.alu_x !== x || bus.alu_y !== y) bad++;
         end
         if (bus.out_valid === 1'b1 || lat >= 200) break;
      end
      check_eq($sformatf("%s_latency", tag), lat, exp_lat);
      check_eq($sformatf("%s_drive_cycles", tag), drive, exp_drive);
      check_eq($sformatf("%s_drive_stable", tag), bad, 0);
      check_eq($sformatf("%s_result", tag), bus.out_result, exp_res);
      check_eq($sformatf("%s_remainder", tag), bus.out_remainder, 67'(exp_rem));
      check_eq($sformatf("%s_err", tag), bus.out_err, 67'(exp_err));
   endtask

   // called at the negedge of a HOLD cycle with out_ready high
   task automatic finish_handshake(input string tag);
      @(negedge clk);
      check_eq($sformatf("%s_gap_state", tag), dbg_state, ST_GAP);
      check_eq($sformatf("%s_gap_alu_op", tag), bus.alu_op, 0);
      check_eq($sformatf("%s_gap_in_ready", tag), bus.in_ready, 0);
      check_eq($sformatf("%s_gap_out_valid", tag), bus.out_valid, 0);
      @(negedge clk);
      check_eq($sformatf("%s_idle_in_ready", tag), bus.in_ready, 1);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq($sformatf("%s_state", tag), dbg_state, ST_IDLE);
      check_eq($sformatf("%s_in_ready", tag), bus.in_ready, 1);
      check_eq($sformatf("%s_out_valid", tag), bus.out_valid, 0);
      check_eq($sformatf("%s_out_err", tag), bus.out_err, 0);
      check_eq($sformatf("%s_alu_op", tag), bus.alu_op, 0);
      check_eq($sformatf("%s_alu_x", tag), bus.alu_x, 0);
      check_eq($sformatf("%s_alu_y", tag), bus.alu_y, 0);
      check_eq($sformatf("%s_out_result", tag), bus.out_result, 0);
      check_eq($sformatf("%s_out_remainder", tag), bus.out_remainder, 0);
   endtask

   initial begin
      logic [66:0] snap_res;
      int          unstable;
      int          pulses;

      bus.in_valid  = 1'b0;
      bus.in_op     = 5'd0;
      bus.in_x      = 32'd0;
      bus.in_y      = 32'd0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      @(negedge clk);

      run_op("add", 5'd1, 32'd172, 32'd230, 3, 2, 67'd402, 33'd0, 1'b0);
      finish_handshake("add");

      run_op("sub", 5'd2, 32'd50, 32'd8, 3, 2, 67'd42, 33'd0, 1'b0);
      finish_handshake("sub");

      run_op("mul", 5'd3, 32'hFFFF_FFFF, 32'd2, 35, 34, 67'h1_FFFF_FFFE, 33'd0, 1'b0);
      finish_handshake("mul");

      run_op("div", 5'd4, 32'd100, 32'd7, 35, 34, 67'd14, 33'd2, 1'b0);
      finish_handshake("div");

      run_op("div0", 5'd4, 32'd100, 32'd0, 1, 0, 67'd0, 33'd0, 1'b1);
      finish_handshake("div0");

      run_op("badop", 5'd12, 32'd3, 32'd4, 1, 0, 67'd0, 33'd0, 1'b1);
      finish_handshake("badop");

      // back-pressure: result must sit untouched while out_ready is low
      bus.out_ready = 1'b0;
      run_op("and", 5'd7, 32'hF0F0_1234, 32'h0FF0_FF00, 3, 2, 67'h00F0_1200, 33'd0, 1'b0);
      snap_res = bus.out_result;
      unstable = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b1 || bus.out_result !== snap_res ||
             bus.in_ready !== 1'b0 || bus.out_err !== 1'b0 || bus.alu_op !== 5'd0)
            unstable++;
      end
      check_eq("stall_stable", unstable, 0);
      check_eq("stall_state", dbg_state, ST_HOLD);
      bus.out_ready = 1'b1;
      finish_handshake("stall");

      // reset during RUN cycle 10 of a divide
      issue(5'd4, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      check_eq("abort_run_alu_op", bus.alu_op, 4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("abort");
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) pulses++;
      end
      check_eq("abort_no_output", pulses, 0);

      run_op("add2", 5'd1, 32'd5, 32'd9, 3, 2, 67'd14, 33'd0, 1'b0);
      finish_handshake("add2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
